// File: rtl/pmodclp_lcd_sequencer_pkg.sv
// Shared types and constants for the PmodCLP HD44780 write sequencer:
// state encoding, power-up init ROM, long-execution opcodes and default timings (100 MHz).
package pmodclp_pkg;

   typedef enum logic [2:0] {
      ST_INIT_WAIT,
      ST_INIT_CMD,
      ST_IDLE,
      ST_SETUP,
      ST_ENABLE,
      ST_HOLD,
      ST_EXEC_WAIT
   } seq_state_e;

   localparam int unsigned DEF_T_SETUP_CYC   = 8;
   localparam int unsigned DEF_T_EN_CYC      = 25;
   localparam int unsigned DEF_T_HOLD_CYC    = 4;
   localparam int unsigned DEF_T_EXEC_CYC    = 4000;
   localparam int unsigned DEF_T_CLEAR_CYC   = 164000;
   localparam int unsigned DEF_INIT_WAIT_CYC = 2000000;

   localparam logic [7:0] OP_CLEAR     = 8'h01;
   localparam logic [7:0] OP_HOME      = 8'h02;
   localparam logic [7:0] OP_HOME_ALT  = 8'h03;

   localparam int unsigned INIT_LEN = 5;

   // 8-bit bus, 2 lines; display on; clear; entry mode increment.
   function automatic logic [7:0] init_byte(input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = 8'h38;
         3'd1:    b = 8'h38;
         3'd2:    b = 8'h0C;
         3'd3:    b = 8'h01;
         default: b = 8'h06;
      endcase
      return b;
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
      return !rs && (d == OP_CLEAR || d == OP_HOME || d == OP_HOME_ALT);
   endfunction

endpackage

// File: rtl/pmodclp_lcd_sequencer_timer.sv
// Loadable down-counter shared by every sequencer phase; done is high while the count is zero.
// A load of N-1 therefore ends the phase N cycles later.
module lcd_delay_timer #(
   parameter int unsigned     W       = 8,
   parameter logic [W-1:0]    RST_VAL = '0
) (
   input  logic          sysclk,
   input  logic          sysreset_n,
   input  logic          load,
   input  logic [W-1:0]  value,
   output logic          done
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = value;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge sysclk or negedge sysreset_n) begin
      if (!sysreset_n)
         cnt_q <= RST_VAL;
      else
         cnt_q <= cnt_d;
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/pmodclp_lcd_sequencer.sv
// Write-only HD44780 sequencer: one byte per handshake, ready again 1+setup+enable+hold+exec cycles after accept;
// requests while busy are ignored. Define PMODCLP_INIT_SEQ_EN to run the power-up init sequence after reset.
module pmodclp_lcd_sequencer
   import pmodclp_pkg::*;
#(
   parameter int unsigned T_SETUP_CYC   = DEF_T_SETUP_CYC,
   parameter int unsigned T_EN_CYC      = DEF_T_EN_CYC,
   parameter int unsigned T_HOLD_CYC    = DEF_T_HOLD_CYC,
   parameter int unsigned T_EXEC_CYC    = DEF_T_EXEC_CYC,
   parameter int unsigned T_CLEAR_CYC   = DEF_T_CLEAR_CYC,
   parameter int unsigned INIT_WAIT_CYC = DEF_INIT_WAIT_CYC
) (
   input  logic        sysclk,
   input  logic        sysreset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rs,
   input  logic [7:0]  req_data,
   output logic        busy,
   output logic        init_done,
   output logic [7:0]  lcd_d,
   output logic        lcd_rs,
   output logic        lcd_rw,
   output logic        lcd_e
);

   localparam int unsigned MAX_CYC = max_u(max_u(max_u(T_SETUP_CYC, T_EN_CYC),
                                                 max_u(T_HOLD_CYC, T_EXEC_CYC)),
                                           max_u(T_CLEAR_CYC, INIT_WAIT_CYC));
   localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

`ifdef PMODCLP_INIT_SEQ_EN
   localparam seq_state_e       RST_STATE = ST_INIT_WAIT;
   localparam logic [CNT_W-1:0] TMR_RST   = CNT_W'(INIT_WAIT_CYC - 1);
`else
   localparam seq_state_e       RST_STATE = ST_IDLE;
   localparam logic [CNT_W-1:0] TMR_RST   = '0;
`endif

   seq_state_e       state_q, state_d;
   logic [7:0]       lcd_d_q, lcd_d_d;
   logic             lcd_rs_q, lcd_rs_d;
   logic             lcd_e_q, lcd_e_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             init_done_q, init_done_d;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_value;
   logic             tmr_done;
`ifdef PMODCLP_INIT_SEQ_EN
   logic [2:0]       idx_q, idx_d;
`endif

   always_comb begin
      state_d     = state_q;
      lcd_d_d     = lcd_d_q;
      lcd_rs_d    = lcd_rs_q;
      lcd_e_d     = lcd_e_q;
      ready_d     = ready_q;
      busy_d      = busy_q;
      init_done_d = init_done_q;
      tmr_load    = 1'b0;
      tmr_value   = '0;
`ifdef PMODCLP_INIT_SEQ_EN
      idx_d       = idx_q;
`endif
      case (state_q)
         ST_INIT_WAIT: begin
            busy_d = 1'b1;
            if (tmr_done)
               state_d = ST_INIT_CMD;
         end
         ST_INIT_CMD: begin
`ifdef PMODCLP_INIT_SEQ_EN
            lcd_d_d = init_byte(idx_q);
`endif
            lcd_rs_d  = 1'b0;
            tmr_load  = 1'b1;
            tmr_value = CNT_W'(T_SETUP_CYC - 1);
            state_d   = ST_SETUP;
         end
         ST_IDLE: begin
            ready_d     = 1'b1;
            busy_d      = 1'b0;
            init_done_d = 1'b1;
            // ready_q gates acceptance so the first post-reset cycle cannot capture a byte.
            if (req_valid && ready_q) begin
               lcd_d_d   = req_data;
               lcd_rs_d  = req_rs;
               ready_d   = 1'b0;
               busy_d    = 1'b1;
               tmr_load  = 1'b1;
               tmr_value = CNT_W'(T_SETUP_CYC - 1);
               state_d   = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (tmr_done) begin
               lcd_e_d   = 1'b1;
               tmr_load  = 1'b1;
               tmr_value = CNT_W'(T_EN_CYC - 1);
               state_d   = ST_ENABLE;
            end
         end
         ST_ENABLE: begin
            if (tmr_done) begin
               lcd_e_d   = 1'b0;
               tmr_load  = 1'b1;
               tmr_value = CNT_W'(T_HOLD_CYC - 1);
               state_d   = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (tmr_done) begin
               tmr_load  = 1'b1;
               tmr_value = is_long_cmd(lcd_rs_q, lcd_d_q) ? CNT_W'(T_CLEAR_CYC - 1)
                                                          : CNT_W'(T_EXEC_CYC - 1);
               state_d   = ST_EXEC_WAIT;
            end
         end
         ST_EXEC_WAIT: begin
            if (tmr_done) begin
`ifdef PMODCLP_INIT_SEQ_EN
               if (!init_done_q && idx_q != 3'(INIT_LEN - 1)) begin
                  idx_d   = idx_q + 3'd1;
                  state_d = ST_INIT_CMD;
               end else
`endif
               begin
                  state_d     = ST_IDLE;
                  ready_d     = 1'b1;
                  busy_d      = 1'b0;
                  init_done_d = 1'b1;
               end
            end
         end
         default: state_d = RST_STATE;
      endcase
   end

   always_ff @(posedge sysclk or negedge sysreset_n) begin
      if (!sysreset_n) begin
         state_q     <= RST_STATE;
         lcd_d_q     <= '0;
         lcd_rs_q    <= 1'b0;
         lcd_e_q     <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b1;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lcd_d_q     <= lcd_d_d;
         lcd_rs_q    <= lcd_rs_d;
         lcd_e_q     <= lcd_e_d;
         ready_q     <= ready_d;
         busy_q      <= busy_d;
         init_done_q <= init_done_d;
      end
   end

`ifdef PMODCLP_INIT_SEQ_EN
   always_ff @(posedge sysclk or negedge sysreset_n) begin
      if (!sysreset_n)
         idx_q <= '0;
      else
         idx_q <= idx_d;
   end
`endif

   lcd_delay_timer #(
      .W       (CNT_W),
      .RST_VAL (TMR_RST)
   ) u_timer (
      .sysclk     (sysclk),
      .sysreset_n (sysreset_n),
      .load       (tmr_load),
      .value      (tmr_value),
      .done       (tmr_done)
   );

   assign lcd_d     = lcd_d_q;
   assign lcd_rs    = lcd_rs_q;
   assign lcd_rw    = 1'b0;
   assign lcd_e     = lcd_e_q;
   assign req_ready = ready_q;
   assign busy      = busy_q;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_pmodclp_lcd_sequencer.sv
// Randomised bench for pmodclp_lcd_sequencer with scaled-down timings; expected timings and bus
// contents come from the write rules (setup/enable/hold/exec lengths, clear/home opcodes).
module tb_pmodclp_lcd_sequencer;

   localparam int unsigned S  = 8;
   localparam int unsigned E  = 25;
   localparam int unsigned H  = 4;
   localparam int unsigned X  = 400;
   localparam int unsigned C  = 1640;
   localparam int unsigned IW = 300;
   localparam int          TMO = int'(C + S + E + H) + 64;

   logic       sysclk = 1'b0;
   logic       sysreset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_rs = 1'b0;
   logic [7:0] req_data = 8'h00;
   logic       req_ready, busy, init_done, lcd_rs, lcd_rw, lcd_e;
   logic [7:0] lcd_d;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 sysclk = ~sysclk;

   pmodclp_lcd_sequencer #(
      .T_SETUP_CYC   (S),
      .T_EN_CYC      (E),
      .T_HOLD_CYC    (H),
      .T_EXEC_CYC    (X),
      .T_CLEAR_CYC   (C),
      .INIT_WAIT_CYC (IW)
   ) dut (
      .sysclk     (sysclk),
      .sysreset_n (sysreset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rs     (req_rs),
      .req_data   (req_data),
      .busy       (busy),
      .init_done  (init_done),
      .lcd_d      (lcd_d),
      .lcd_rs     (lcd_rs),
      .lcd_rw     (lcd_rw),
      .lcd_e      (lcd_e)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Handshake cycle counts as cycle 0; ready is seen again in cycle 1+S+E+H+wait.
   function automatic int exp_gap(input logic rs, input logic [7:0] d);
      int w;
      w = (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) ? int'(C) : int'(X);
      return 1 + int'(S + E + H) + w;
   endfunction

   task automatic after_release();
`ifdef PMODCLP_INIT_SEQ_EN
      logic [7:0] got[$];
      logic [7:0] exp_b[5];
      int         n;
      logic       prev_e;
      int         rs_bad;
      exp_b  = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      n      = 0;
      prev_e = 1'b0;
      rs_bad = 0;
      @(negedge sysclk);
      check("init_done_early", init_done, 1'b0);
      while (!req_ready && n < 20000) begin
         @(negedge sysclk);
         n++;
         if (lcd_e && !prev_e) begin
            got.push_back(lcd_d);
            if (lcd_rs) rs_bad++;
         end
         prev_e = lcd_e;
      end
      check("init_pulses", got.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < got.size()) check("init_byte", got[i], exp_b[i]);
      check("init_rs", rs_bad, 0);
      check("init_done_end", init_done, 1'b1);
      check("init_ready", req_ready, 1'b1);
`else
      @(negedge sysclk);
      check("init_done_rel", init_done, 1'b1);
      if (!req_ready) @(negedge sysclk);
      check("ready_rel", req_ready, 1'b1);
`endif
   endtask

   task automatic do_write(input logic rs, input logic [7:0] d, input bit hold);
      int   n, setup_n, e_n, pulses, bad;
      logic prev_e;
      n = 0;
      while (!req_ready && n < TMO) begin
         @(negedge sysclk);
         n++;
      end
      if (!req_ready) begin
         check("ready_timeout", req_ready, 1'b1);
         return;
      end
      req_valid = 1'b1;
      req_rs    = rs;
      req_data  = d;
      @(posedge sysclk);
      #1;
      if (hold) req_data = 8'($urandom);
      else      req_valid = 1'b0;
      n = 0; setup_n = 0; e_n = 0; pulses = 0; bad = 0; prev_e = 1'b0;
      do begin
         @(negedge sysclk);
         n++;
         if (hold) req_data = 8'($urandom);
         if (lcd_d !== d || lcd_rs !== rs || lcd_rw !== 1'b0) bad++;
         if (!req_ready && !busy) bad++;
         if (lcd_e && !prev_e) pulses++;
         if (lcd_e) e_n++;
         else if (pulses == 0) setup_n++;
         prev_e = lcd_e;
      end while (!req_ready && n < TMO);
      check("bus_stable", bad, 0);
      check("e_pulses", pulses, 1);
      check("setup_len", setup_n, S);
      check("e_width", e_n, E);
      check("ready_gap", n, exp_gap(rs, d));
      check("busy_idle", busy, 1'b0);
      if (!hold) begin
         @(negedge sysclk);
         check("idle_hold", {lcd_rs, lcd_d}, {rs, d});
      end
   endtask

   task automatic reset_in_enable();
      int n;
      int strobes;
      n = 0;
      strobes = 0;
      while (!req_ready && n < TMO) begin
         @(negedge sysclk);
         n++;
      end
      req_valid = 1'b1;
      req_rs    = 1'b1;
      req_data  = 8'($urandom);
      @(posedge sysclk);
      #1 req_valid = 1'b0;
      n = 0;
      while (!lcd_e && n < TMO) begin
         @(negedge sysclk);
         n++;
      end
      check("enable_reached", lcd_e, 1'b1);
      repeat ($urandom_range(0, E - 3)) @(negedge sysclk);
      check("enable_before_rst", lcd_e, 1'b1);
      #2 sysreset_n = 1'b0;
      #1;
      check("e_async_drop", lcd_e, 1'b0);
      check("ready_in_rst", req_ready, 1'b0);
      check("busy_in_rst", busy, 1'b1);
      repeat (3) @(negedge sysclk);
      sysreset_n = 1'b1;
      after_release();
`ifndef PMODCLP_INIT_SEQ_EN
      repeat (200) begin
         @(negedge sysclk);
         if (lcd_e) strobes++;
      end
      check("no_strobe_after_rst", strobes, 0);
`endif
   endtask

   initial begin
      logic       rs;
      logic [7:0] d;
      bit         hold;

      repeat (4) @(negedge sysclk);
      check("rst_lcd_d", lcd_d, 8'h00);
      check("rst_lcd_rs", lcd_rs, 1'b0);
      check("rst_lcd_rw", lcd_rw, 1'b0);
      check("rst_lcd_e", lcd_e, 1'b0);
      check("rst_ready", req_ready, 1'b0);
      check("rst_busy", busy, 1'b1);
      check("rst_init_done", init_done, 1'b0);
      sysreset_n = 1'b1;
      after_release();

      do_write(1'b1, 8'h41, 1'b0);
      do_write(1'b0, 8'h01, 1'b0);
      do_write(1'b0, 8'h80, 1'b0);
      do_write(1'b0, 8'h03, 1'b0);
      do_write(1'b0, 8'h04, 1'b0);
      do_write(1'b1, 8'h01, 1'b0);
      do_write(1'b1, 8'h55, 1'b1);
      do_write(1'b0, 8'hC0, 1'b0);

      for (int i = 0; i < 14; i++) begin
         rs   = 1'($urandom_range(0, 1));
         d    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
         hold = (i < 13) && ($urandom_range(0, 3) == 0);
         do_write(rs, d, hold);
         if (!hold) repeat ($urandom_range(0, 5)) @(negedge sysclk);
      end

      reset_in_enable();
      do_write(1'b0, 8'h02, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
